// File: rtl/pong_pkg.sv
// Shared definitions for the pong powerup logic: FSM and mode encodings,
// screen geometry, spawn offsets and the LFSR seed and step function.
package pong_pkg;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        SPAWN = 2'd1,
        SHOW  = 2'd2,
        EAT   = 2'd3
    } pp_state_e;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } pp_mode_e;

    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 768;

    // A 9-bit random offset from these keeps the powerup inside the centre of the screen
    localparam logic [9:0] PP_X_OFFSET = 10'd256;
    localparam logic [9:0] PP_Y_OFFSET = 10'd192;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci form, taps 16,14,13,11: shift left and feed the XOR into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

endpackage

// File: rtl/powerup_spawner_if.sv
// Signal bundle between the game core (master) and the powerup spawner (slave).
interface powerup_spawner_if;

    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] pp_status;
    logic       pp_visible;
    logic [9:0] pp_x;
    logic [9:0] pp_y;
    logic       eaten;
    logic [1:0] mode;

    modport master (
        output ball_x, ball_y, pp_status,
        input  pp_visible, pp_x, pp_y, eaten, mode
    );

    modport slave (
        input  ball_x, ball_y, pp_status,
        output pp_visible, pp_x, pp_y, eaten, mode
    );

endinterface

// File: rtl/powerup_spawner_lfsr16.sv
// 16-bit Fibonacci LFSR that free-runs every cycle; seeded on reset so it is never 0.
module lfsr16
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb lfsr_d = lfsr_step(lfsr_q);

    // NOTE: sequential state uses <= so every flop samples pre-edge values, avoiding races.
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign out = lfsr_q;

endmodule

// File: rtl/powerup_spawner.sv
// Powerup spawner: waits RESPAWN_S seconds, spawns a powerup at a pseudo-random spot and
// mode, shows it until the ball overlaps it. Define PP_LIFETIME_EN to add a lifetime expiry.
module powerup_spawner
    import pong_pkg::*;
#(
    parameter int PRESCALER  = 64999999,
    parameter int RESPAWN_S  = 4,
    parameter int LIFETIME_S = 6,
    parameter int PP_SIZE    = 16,
    parameter int BALL_SIZE  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [3:0] pp_status,
    output logic       pp_visible,
    output logic [9:0] pp_x,
    output logic [9:0] pp_y,
    output logic       eaten,
    output logic [1:0] mode
);

    localparam int                 PRESC_W      = (PRESCALER > 0) ? $clog2(PRESCALER + 1) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX    = PRESC_W'(PRESCALER);
    localparam logic [3:0]         RESPAWN_INIT = 4'(RESPAWN_S);

    if (RESPAWN_S < 1 || RESPAWN_S > 15) begin : g_bad_respawn
        $error("RESPAWN_S must be in 1..15");
    end
    if (LIFETIME_S < 1 || LIFETIME_S > 15) begin : g_bad_lifetime
        $error("LIFETIME_S must be in 1..15");
    end

    logic [15:0] lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .out   (lfsr)
    );

    pp_state_e          state_q, state_d;
    logic [3:0]         sec_q, sec_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [9:0]         pp_x_q, pp_x_d;
    logic [9:0]         pp_y_q, pp_y_d;
    pp_mode_e           mode_q, mode_d;
    logic               overlap_q, overlap_d;

    logic        tick;
    logic        hit;
    logic [1:0]  cand;
    logic [10:0] bx, by, px, py;

    assign tick = (presc_q == PRESC_MAX);
    assign cand = lfsr[10:9];

    // 11-bit compare so pp_x+PP_SIZE near 1023 cannot wrap and fake an overlap
    assign bx  = {1'b0, ball_x};
    assign by  = {1'b0, ball_y};
    assign px  = {1'b0, pp_x_q};
    assign py  = {1'b0, pp_y_q};
    assign hit = (bx < px + 11'(PP_SIZE)) && (bx + 11'(BALL_SIZE) > px) &&
                 (by < py + 11'(PP_SIZE)) && (by + 11'(BALL_SIZE) > py);

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_d   = state_q;
        sec_d     = sec_q;
        presc_d   = presc_q;
        pp_x_d    = pp_x_q;
        pp_y_d    = pp_y_q;
        mode_d    = mode_q;
        overlap_d = 1'b0;

        unique case (state_q)
            WAIT: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (sec_q == 4'd0) begin
                    state_d = SPAWN;
                end else if (tick) begin
                    sec_d = sec_q - 4'd1;
                end
            end

            SPAWN: begin
                pp_x_d  = PP_X_OFFSET + {1'b0, lfsr[8:0]};
                pp_y_d  = PP_Y_OFFSET + {1'b0, lfsr[15:7]};
                // Only one skip past an already-active mode, even if the next is active too
                mode_d  = pp_status[cand] ? pp_mode_e'(cand + 2'd1) : pp_mode_e'(cand);
                presc_d = '0;
`ifdef PP_LIFETIME_EN
                sec_d   = 4'(LIFETIME_S);
`endif
                state_d = SHOW;
            end

            SHOW: begin
                overlap_d = hit;
                if (overlap_q) begin
                    state_d = EAT;
`ifdef PP_LIFETIME_EN
                end else if (tick && sec_q == 4'd1) begin
                    state_d = WAIT;
                    sec_d   = RESPAWN_INIT;
                    presc_d = '0;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) sec_d = sec_q - 4'd1;
`endif
                end
            end

            EAT: begin
                state_d = WAIT;
                sec_d   = RESPAWN_INIT;
                presc_d = '0;
            end

            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WAIT;
            sec_q     <= RESPAWN_INIT;
            presc_q   <= '0;
            pp_x_q    <= '0;
            pp_y_q    <= '0;
            mode_q    <= MODE0;
            overlap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            pp_x_q    <= pp_x_d;
            pp_y_q    <= pp_y_d;
            mode_q    <= mode_d;
            overlap_q <= overlap_d;
        end
    end

    assign pp_visible = (state_q == SHOW);
    assign eaten      = (state_q == EAT);
    assign pp_x       = pp_x_q;
    assign pp_y       = pp_y_q;
    assign mode       = mode_q;

endmodule

// File: tb/tb_powerup_spawner.sv
// Directed bench for powerup_spawner with PRESCALER=9, RESPAWN_S=2, LIFETIME_S=3.
// Define PP_LIFETIME_EN for both RTL and bench to exercise the lifetime build.
`timescale 1ns/1ps
module tb_powerup_spawner;

    localparam int PRESCALER  = 9;
    localparam int RESPAWN_S  = 2;
    localparam int LIFETIME_S = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    powerup_spawner_if bus ();

    powerup_spawner #(
        .PRESCALER  (PRESCALER),
        .RESPAWN_S  (RESPAWN_S),
        .LIFETIME_S (LIFETIME_S),
        .PP_SIZE    (16),
        .BALL_SIZE  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ball_x     (bus.ball_x),
        .ball_y     (bus.ball_y),
        .pp_status  (bus.pp_status),
        .pp_visible (bus.pp_visible),
        .pp_x       (bus.pp_x),
        .pp_y       (bus.pp_y),
        .eaten      (bus.eaten),
        .mode       (bus.mode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Independent reference LFSR; lfsr_prev holds the value of the previous cycle
    logic [15:0] lfsr_m;
    logic [15:0] lfsr_prev;

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always @(posedge clk) begin
        lfsr_prev <= lfsr_m;
        lfsr_m    <= reset ? 16'hACE1 : ref_step(lfsr_m);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_visible(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.pp_visible && n < 300);
    endtask

    task automatic wait_eaten(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.eaten && n < 50);
    endtask

    // Call in the first SHOW cycle: lfsr_prev is then the value seen during SPAWN
    task automatic check_spawn(input string tag, input logic [3:0] status,
                               output logic [9:0] ex, output logic [9:0] ey,
                               output logic [1:0] em);
        logic [1:0] m;
        m  = lfsr_prev[10:9];
        ex = 10'd256 + {1'b0, lfsr_prev[8:0]};
        ey = 10'd192 + {1'b0, lfsr_prev[15:7]};
        em = status[m] ? m + 2'd1 : m;
        check({tag, "_x"}, bus.pp_x, ex);
        check({tag, "_y"}, bus.pp_y, ey);
        check({tag, "_mode"}, bus.mode, em);
        check({tag, "_x_range"}, (bus.pp_x >= 10'd256 && bus.pp_x <= 10'd767), 1);
        check({tag, "_y_range"}, (bus.pp_y >= 10'd192 && bus.pp_y <= 10'd703), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic       seen;
        logic       dropped;
        logic [9:0] ex, ey, first_x, first_y;
        logic [1:0] em, first_mode;

        bus.ball_x    = '0;
        bus.ball_y    = '0;
        bus.pp_status = 4'b0000;

        reset = 1'b1;
        repeat (3) step();
        check("rst_visible", bus.pp_visible, 0);
        check("rst_eaten",   bus.eaten, 0);
        check("rst_pp_x",    bus.pp_x, 0);
        check("rst_pp_y",    bus.pp_y, 0);
        check("rst_mode",    bus.mode, 0);

        reset = 1'b0;
        step();
        wait_visible(n);
        check("spawn_latency", n, 21);
        check_spawn("spawn1", 4'b0000, first_x, first_y, first_mode);

        // Ball centred on the powerup
        bus.ball_x = bus.pp_x + 10'd8;
        bus.ball_y = bus.pp_y + 10'd8;
        wait_eaten(n);
        check("eat_latency", n, 2);
        check("eat_mode", bus.mode, first_mode);
        check("eat_visible", bus.pp_visible, 0);
        bus.ball_x    = '0;
        bus.ball_y    = '0;
        bus.pp_status = 4'b1111;
        step();
        check("eaten_one_cycle", bus.eaten, 0);
        wait_visible(n);
        check("respawn_latency", n, 22);
        check_spawn("spawn_all_active", 4'b1111, ex, ey, em);

        // Touching edges do not overlap
        bus.ball_x = bus.pp_x + 10'd16;
        bus.ball_y = bus.pp_y;
        seen = 1'b0;
        repeat (6) begin
            step();
            if (bus.eaten) seen = 1'b1;
        end
        check("edge_no_eat", seen, 0);
        check("edge_still_visible", bus.pp_visible, 1);
        bus.ball_x = bus.pp_x + 10'd15;
        wait_eaten(n);
        check("inner_edge_eat_latency", n, 2);
        check("inner_edge_mode", bus.mode, em);
        bus.ball_x    = '0;
        bus.ball_y    = '0;
        bus.pp_status = 4'b0101;
        wait_visible(n);
        check("respawn2_latency", n, 23);
        check_spawn("spawn_partial", 4'b0101, ex, ey, em);

`ifdef PP_LIFETIME_EN
        n    = 0;
        seen = 1'b0;
        do begin
            step();
            n++;
            if (bus.eaten) seen = 1'b1;
        end while (bus.pp_visible && n < 100);
        check("lifetime_expiry", n, 30);
        check("expiry_no_eat", seen, 0);
        bus.pp_status = 4'b0000;
        wait_visible(n);
        check("respawn_after_expiry", n, 22);
        check_spawn("spawn_after_expiry", 4'b0000, ex, ey, em);
`else
        seen    = 1'b0;
        dropped = 1'b0;
        repeat (1000) begin
            step();
            if (bus.eaten) seen = 1'b1;
            if (!bus.pp_visible) dropped = 1'b1;
        end
        check("persist_visible", dropped, 0);
        check("persist_no_eat", seen, 0);
        check("persist_mode", bus.mode, em);
`endif

        // Reset while an overlap is already registered
        bus.ball_x = bus.pp_x + 10'd8;
        bus.ball_y = bus.pp_y + 10'd8;
        step();
        check("pre_reset_no_eat", bus.eaten, 0);
        reset = 1'b1;
        step();
        check("mid_rst_eaten",   bus.eaten, 0);
        check("mid_rst_visible", bus.pp_visible, 0);
        check("mid_rst_pp_x",    bus.pp_x, 0);
        check("mid_rst_pp_y",    bus.pp_y, 0);
        check("mid_rst_mode",    bus.mode, 0);
        reset         = 1'b0;
        bus.ball_x    = '0;
        bus.ball_y    = '0;
        bus.pp_status = 4'b0000;
        step();
        check("post_rst_no_eat", bus.eaten, 0);
        wait_visible(n);
        check("post_rst_spawn_latency", n, 21);
        check_spawn("post_rst_spawn", 4'b0000, ex, ey, em);
        check("post_rst_same_x", ex, first_x);
        check("post_rst_same_y", ey, first_y);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/powerup_spawner.md
POWERUP_SPAWNER -- requirements
Module: powerup_spawner

Interface
REQ-001 SHALL have parameter PRESCALER, default 64999999, meaning clk cycles per 1 s tick minus one (65 MHz clock).
REQ-002 SHALL have parameter RESPAWN_S, default 4, meaning seconds between consumption or expiry and the next spawn (1..15).
REQ-003 SHALL have parameter LIFETIME_S, default 6, meaning seconds a powerup stays visible if not eaten (1..15).
REQ-004 SHALL have parameter PP_SIZE, default 16, meaning powerup square side in pixels.
REQ-005 SHALL have parameter BALL_SIZE, default 16, meaning ball square side in pixels.
REQ-006 SHALL have port clk, input, 1 bit, the system clock.
REQ-007 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-008 SHALL have port ball_x, input, 10 bits, the ball top-left x.
REQ-009 SHALL have port ball_y, input, 10 bits, the ball top-left y.
REQ-010 SHALL have port pp_status, input, 4 bits, the active powerups from the timer block; bit n corresponds to mode n.
REQ-011 SHALL have port pp_visible, output, 1 bit, high while a powerup is drawn.
REQ-012 SHALL have port pp_x, output, 10 bits, the powerup top-left x.
REQ-013 SHALL have port pp_y, output, 10 bits, the powerup top-left y.
REQ-014 SHALL have port eaten, output, 1 bit, a one-cycle consumption pulse.
REQ-015 SHALL have port mode, output, 2 bits, the powerup type; it is valid while pp_visible or eaten is high.

Function
REQ-016 SHALL implement FSM states WAIT, SPAWN, SHOW and EAT.
REQ-017 WAIT SHALL load a 4-bit seconds counter with RESPAWN_S on entry, decrement it on each 1 s tick, and go to SPAWN in the cycle after the count reaches 0.
REQ-018 SPAWN SHALL last one cycle and latch pp_x = 256 + lfsr[8:0] and pp_y = 192 + lfsr[15:7] (9-bit zero-extended add), then go to SHOW.
REQ-019 SPAWN SHALL latch candidate mode m = lfsr[10:9], or (m+1) mod 4 when pp_status[m] = 1; only one skip SHALL be applied, even if the next mode is also active.
REQ-020 SHOW SHALL drive pp_visible = 1 and SHALL hold pp_x, pp_y and mode constant.
REQ-021 SHOW SHALL register the overlap term: ball_x < pp_x+PP_SIZE && ball_x+BALL_SIZE > pp_x && ball_y < pp_y+PP_SIZE && ball_y+BALL_SIZE > pp_y, with all arithmetic 11 bits wide (no wrap).
REQ-022 A registered overlap in SHOW SHALL go to EAT on the next cycle; eaten SHALL be asserted exactly while in EAT (one cycle), with pp_visible = 0 and mode unchanged; EAT SHALL then go to WAIT.
REQ-023 Overlap-to-eaten latency SHALL be 2 cycles from the ball_x/ball_y change.
REQ-024 The 1 s prescaler SHALL restart from 0 on every entry to WAIT or SHOW, so the first tick comes PRESCALER+1 cycles after entry.
REQ-025 lfsr SHALL be a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle in all states and is never 0.
REQ-026 eaten SHALL never be asserted twice without an intervening SPAWN.
REQ-027 pp_status SHALL be sampled only in SPAWN.

Reset
REQ-028 Reset SHALL set state WAIT with the seconds counter = RESPAWN_S, the prescaler = 0, lfsr = 16'hACE1, and pp_visible = eaten = 0, pp_x = pp_y = 0, mode = 0.
REQ-029 Reset asserted mid-SHOW or in EAT SHALL take effect the next cycle, and eaten SHALL not be asserted in that cycle.

Configuration
REQ-030 With PP_LIFETIME_EN defined, SHOW SHALL load a counter with LIFETIME_S on entry, decrement it per tick, and go to WAIT without eaten when it reaches 0.
REQ-031 If overlap and lifetime expiry occur in the same cycle, overlap SHALL win (go to EAT).
REQ-032 Without PP_LIFETIME_EN, SHOW SHALL persist until overlap, LIFETIME_S SHALL be ignored, and no lifetime logic SHALL be synthesized.

Structure
REQ-033 Shared package pong_pkg SHALL hold the FSM state encoding, the mode encoding (0..3), the screen constants (1024x768), the offsets 256/192, and the LFSR seed.
REQ-034 The LFSR SHALL be the sub-module lfsr16 (clk, reset, out[15:0]); the FSM, prescaler and collision logic SHALL stay in powerup_spawner.

Verification (PRESCALER=9, RESPAWN_S=2, LIFETIME_S=3)
REQ-035 Release reset -> pp_visible rises exactly 21 cycles later, with 256 <= pp_x <= 767 and 192 <= pp_y <= 703.
REQ-036 In SHOW, drive ball_x = pp_x+8, ball_y = pp_y+8 -> eaten high for exactly 1 cycle 2 cycles later, mode equals the latched mode, pp_visible low, and the next spawn follows 2 s later.
REQ-037 Drive ball_x = pp_x+16, ball_y = pp_y (edge touch) -> no eaten; ball_x = pp_x+15 -> eaten.
REQ-038 With PP_LIFETIME_EN and no ball contact -> pp_visible low after 30 cycles, no eaten pulse; without the macro -> pp_visible stays high for 1000 cycles.
REQ-039 Force pp_status = 4'b1111 and lfsr[10:9] = 2 at SPAWN -> mode = 3; with pp_status = 4'b0000 -> mode = 2.
REQ-040 Assert reset in SHOW while overlap is registered -> no eaten, all outputs 0 on the next cycle, and the spawn sequence repeats as in REQ-035.
